// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - RV32I opcodes, ALU/writeback encodings and controller state type
package multicycle_control_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SLL  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SR   = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_t;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } ctrl_state_t;

    // The ALU result for BEQ/BNE is rs1-rs2, for the others it is the slt bit,
    // so zero means "equal" for the first pair and "not less" for the rest.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        case (funct3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return !zero;
            3'b101:  return zero;
            3'b110:  return !zero;
            3'b111:  return zero;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - fetch handshake, ALU control, memory and writeback signals
interface multicycle_control_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [2:0]  alu_op;
    logic        alu_b_negate;
    logic        alu_b_add_one;
    logic        alu_sign;
    logic        alu_zero_flag;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic        pc_sel;
    logic        illegal;

    modport master (
        input  instr_valid, instr, alu_zero_flag, mem_ack,
        output instr_ready, alu_op, alu_b_negate, alu_b_add_one, alu_sign,
               alu_a_sel, alu_b_sel, mem_req, mem_we, reg_we, wb_sel,
               pc_we, pc_sel, illegal
    );

    modport slave (
        output instr_valid, instr, alu_zero_flag, mem_ack,
        input  instr_ready, alu_op, alu_b_negate, alu_b_add_one, alu_sign,
               alu_a_sel, alu_b_sel, mem_req, mem_we, reg_we, wb_sel,
               pc_we, pc_sel, illegal
    );
endinterface

// File: rtl/multicycle_control_alu_ctrl_decode.sv
// rtl/multicycle_control_alu_ctrl_decode.sv - combinational RV32I decode to ALU controls and legality
module alu_ctrl_decode
    import multicycle_control_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_t    alu_op,
    output logic       b_negate,
    output logic       b_add_one,
    output logic       sign,
    output logic       a_sel,
    output logic       b_sel,
    output logic       illegal_dec
);

    // Map opcode/funct fields to ALU controls and flag encodings outside RV32I
    always_comb begin
        alu_op      = ALU_ADD;
        b_negate    = 1'b0;
        b_add_one   = 1'b0;
        sign        = 1'b0;
        a_sel       = 1'b0;
        b_sel       = 1'b0;
        illegal_dec = 1'b0;
        case (opcode)
            OPC_OP: begin
                alu_op = alu_op_t'(funct3);
                if (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    b_negate  = (funct3 == 3'b000);
                    b_add_one = (funct3 == 3'b000);
                    sign      = (funct3 == 3'b101);
                end else if (funct7 != 7'h00) begin
                    illegal_dec = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                alu_op = alu_op_t'(funct3);
                b_sel  = 1'b1;
                if (funct3 == 3'b001 && funct7 != 7'h00)
                    illegal_dec = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == 7'h20)
                        sign = 1'b1;
                    else if (funct7 != 7'h00)
                        illegal_dec = 1'b1;
                end
            end
            OPC_LOAD: begin
                b_sel       = 1'b1;
                illegal_dec = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                b_sel       = 1'b1;
                illegal_dec = funct3[2] || (funct3[1] && funct3[0]);
            end
            OPC_BRANCH: begin
                alu_op      = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_ADD;
                b_negate    = !funct3[2];
                b_add_one   = !funct3[2];
                illegal_dec = (funct3[2:1] == 2'b01);
            end
            OPC_JAL: begin
                a_sel = 1'b1;
                b_sel = 1'b1;
            end
            OPC_JALR: begin
                b_sel       = 1'b1;
                illegal_dec = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                b_sel = 1'b1;
            end
            OPC_AUIPC: begin
                a_sel = 1'b1;
                b_sel = 1'b1;
            end
            default: illegal_dec = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV32I control FSM driving the ALU, memory port and PC
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    multicycle_control_if.master bus
);

    ctrl_state_t state;
    logic [31:0] ir;
    logic        ready_q, illegal_q;
    alu_op_t     op_q;
    logic        neg_q, add1_q, sign_q, a_q, b_q;
    logic        mreq_q, mwe_q, rwe_q, pwe_q, psel_q, br_q;
    wb_sel_t     wb_q;

    alu_op_t     dec_op;
    logic        dec_neg, dec_add1, dec_sign, dec_a, dec_b, dec_illegal;
    wb_sel_t     dec_wb;
    logic        is_branch, is_load, is_store, is_jump;
    logic        retire;
    logic        unused_ir;

    alu_ctrl_decode u_decode (
        .opcode      (ir[6:0]),
        .funct3      (ir[14:12]),
        .funct7      (ir[31:25]),
        .alu_op      (dec_op),
        .b_negate    (dec_neg),
        .b_add_one   (dec_add1),
        .sign        (dec_sign),
        .a_sel       (dec_a),
        .b_sel       (dec_b),
        .illegal_dec (dec_illegal)
    );

    assign is_branch = (ir[6:0] == OPC_BRANCH);
    assign is_load   = (ir[6:0] == OPC_LOAD);
    assign is_store  = (ir[6:0] == OPC_STORE);
    assign is_jump   = (ir[6:0] == OPC_JAL) || (ir[6:0] == OPC_JALR);
    assign unused_ir = ^{ir[24:15], ir[11:7]};

    // Writeback source chosen once per instruction from its opcode
    always_comb begin
        dec_wb = WB_ALU;
        if (ir[6:0] == OPC_LUI)
            dec_wb = WB_IMM;
        else if (is_jump)
            dec_wb = WB_PC4;
        else if (is_load)
            dec_wb = WB_MEM;
    end

    // Last cycle of an instruction: branch resolves in EXEC, store on its ack, everything else in WB
    assign retire = (state == S_EXEC && is_branch)
                 || (state == S_MEM && bus.mem_ack && is_store)
                 || (state == S_WB);

    // Controller state, IR and all registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            ir        <= '0;
            ready_q   <= 1'b0;
            illegal_q <= 1'b0;
            op_q      <= ALU_ADD;
            neg_q     <= 1'b0;
            add1_q    <= 1'b0;
            sign_q    <= 1'b0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            mreq_q    <= 1'b0;
            mwe_q     <= 1'b0;
            rwe_q     <= 1'b0;
            pwe_q     <= 1'b0;
            psel_q    <= 1'b0;
            br_q      <= 1'b0;
            wb_q      <= WB_ALU;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.instr_valid && ready_q) begin
                        ir      <= bus.instr;
                        ready_q <= 1'b0;
                        state   <= S_DECODE;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        illegal_q <= 1'b1;
                        state     <= S_TRAP;
                    end else begin
                        op_q   <= dec_op;
                        neg_q  <= dec_neg;
                        add1_q <= dec_add1;
                        sign_q <= dec_sign;
                        a_q    <= dec_a;
                        b_q    <= dec_b;
                        wb_q   <= dec_wb;
                        pwe_q  <= is_branch;
                        br_q   <= is_branch;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_load || is_store) begin
                        mreq_q <= 1'b1;
                        mwe_q  <= is_store;
                        state  <= S_MEM;
                    end else if (!is_branch) begin
                        rwe_q  <= 1'b1;
                        pwe_q  <= 1'b1;
                        psel_q <= is_jump;
                        state  <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.mem_ack && is_load) begin
                        mreq_q <= 1'b0;
                        mwe_q  <= 1'b0;
                        rwe_q  <= 1'b1;
                        pwe_q  <= 1'b1;
                        psel_q <= 1'b0;
                        state  <= S_WB;
                    end
                end
                S_WB:    state <= S_FETCH;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_TRAP;
            endcase
            if (retire) begin
                state   <= S_FETCH;
                ready_q <= 1'b1;
                op_q    <= ALU_ADD;
                neg_q   <= 1'b0;
                add1_q  <= 1'b0;
                sign_q  <= 1'b0;
                a_q     <= 1'b0;
                b_q     <= 1'b0;
                wb_q    <= WB_ALU;
                mreq_q  <= 1'b0;
                mwe_q   <= 1'b0;
                rwe_q   <= 1'b0;
                pwe_q   <= 1'b0;
                psel_q  <= 1'b0;
                br_q    <= 1'b0;
            end
        end
    end

    assign bus.instr_ready   = ready_q;
    assign bus.alu_op        = op_q;
    assign bus.alu_b_negate  = neg_q;
    assign bus.alu_b_add_one = add1_q;
    assign bus.alu_sign      = sign_q;
    assign bus.alu_a_sel     = a_q;
    assign bus.alu_b_sel     = b_q;
    assign bus.mem_req       = mreq_q;
    assign bus.mem_we        = mwe_q;
    assign bus.reg_we        = rwe_q;
    assign bus.wb_sel        = wb_q;
    assign bus.illegal       = illegal_q;
    // A store retires in the cycle its ack arrives and a branch resolves on the
    // zero flag the ALU returns in EXEC, so these two terms follow the inputs.
    assign bus.pc_we         = pwe_q | (mreq_q & mwe_q & bus.mem_ack);
    assign bus.pc_sel        = psel_q | (br_q & branch_taken(ir[14:12], bus.alu_zero_flag));

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    localparam int K_WB = 0;
    localparam int K_BR = 1;
    localparam int K_LD = 2;
    localparam int K_ST = 3;

    typedef struct {
        logic       ready;
        logic [2:0] op;
        logic       neg, add1, sign, a_sel, b_sel;
        logic       mreq, mwe, rwe;
        logic [1:0] wb;
        logic       pwe, psel, ill;
    } obs_t;

    typedef struct {
        int         kind;
        logic [2:0] op;
        logic       neg, add1, sign, a_sel, b_sel, ops_dc, jump;
        logic [1:0] wb;
    } mdl_t;

    obs_t tr[64];
    int   n_cyc;
    bit   timeout;

    function automatic logic [16:0] outs_now();
        return {bus.instr_ready, bus.alu_op, bus.alu_b_negate, bus.alu_b_add_one,
                bus.alu_sign, bus.alu_a_sel, bus.alu_b_sel, bus.mem_req, bus.mem_we,
                bus.reg_we, bus.wb_sel, bus.pc_we, bus.pc_sel, bus.illegal};
    endfunction

    task automatic sample(output obs_t o);
        o.ready = bus.instr_ready;  o.op   = bus.alu_op;
        o.neg   = bus.alu_b_negate; o.add1 = bus.alu_b_add_one;
        o.sign  = bus.alu_sign;     o.a_sel = bus.alu_a_sel;  o.b_sel = bus.alu_b_sel;
        o.mreq  = bus.mem_req;      o.mwe  = bus.mem_we;      o.rwe  = bus.reg_we;
        o.wb    = bus.wb_sel;       o.pwe  = bus.pc_we;       o.psel = bus.pc_sel;
        o.ill   = bus.illegal;
    endtask

    // Reference model: what the instruction should ask of the datapath
    function automatic mdl_t model(input logic [31:0] w);
        mdl_t m;
        logic [2:0] f3;
        f3 = w[14:12];
        m = '{kind: K_WB, op: 3'd0, neg: 1'b0, add1: 1'b0, sign: 1'b0, a_sel: 1'b0,
              b_sel: 1'b0, ops_dc: 1'b0, jump: 1'b0, wb: 2'b00};
        case (w[6:0])
            7'b0110011: begin
                m.op = f3;
                m.neg = (f3 == 3'd0) && w[30];
                m.add1 = m.neg;
                m.sign = (f3 == 3'd5) && w[30];
            end
            7'b0010011: begin m.op = f3; m.b_sel = 1'b1; m.sign = (f3 == 3'd5) && w[30]; end
            7'b0000011: begin m.kind = K_LD; m.b_sel = 1'b1; m.wb = 2'b01; end
            7'b0100011: begin m.kind = K_ST; m.b_sel = 1'b1; end
            7'b1100011: begin
                m.kind = K_BR;
                m.op = (f3 < 3'd4) ? 3'd0 : ((f3 < 3'd6) ? 3'd2 : 3'd3);
                m.neg = (f3 < 3'd4);
                m.add1 = (f3 < 3'd4);
            end
            7'b1101111: begin m.a_sel = 1'b1; m.b_sel = 1'b1; m.wb = 2'b10; m.jump = 1'b1; end
            7'b1100111: begin m.b_sel = 1'b1; m.wb = 2'b10; m.jump = 1'b1; end
            7'b0110111: begin m.ops_dc = 1'b1; m.wb = 2'b11; end
            default:    begin m.a_sel = 1'b1; m.b_sel = 1'b1; end
        endcase
        return m;
    endfunction

    // Branch outcome from what the ALU zero flag means for each compare
    function automatic logic mdl_taken(input logic [2:0] f3, input logic z);
        logic equal, less;
        equal = z;
        less  = !z;
        case (f3)
            3'd0: return equal;
            3'd1: return !equal;
            3'd4, 3'd6: return less;
            default: return !less;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [2:0]  ld_f3[5];
        logic [2:0]  br_f3[6];
        logic [2:0]  f3;
        int k;
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        w = $urandom;
        f3 = 3'($urandom_range(0, 7));
        k = $urandom_range(0, 8);
        case (k)
            0: begin
                w[6:0] = 7'b0110011;
                w[31:25] = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            1: begin
                w[6:0] = 7'b0010011;
                if (f3 == 3'd1) w[31:25] = 7'h00;
                if (f3 == 3'd5) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            2: begin w[6:0] = 7'b0000011; f3 = ld_f3[$urandom_range(0, 4)]; end
            3: begin w[6:0] = 7'b0100011; f3 = 3'($urandom_range(0, 2)); end
            4: begin w[6:0] = 7'b1100011; f3 = br_f3[$urandom_range(0, 5)]; end
            5: w[6:0] = 7'b1101111;
            6: begin w[6:0] = 7'b1100111; f3 = 3'd0; end
            7: w[6:0] = 7'b0110111;
            default: w[6:0] = 7'b0010111;
        endcase
        if (k != 5 && k != 7 && k != 8) w[14:12] = f3;
        return w;
    endfunction

    // Hand one instruction to the controller and record every cycle until it is ready again.
    // The memory answers d cycles after mem_req is first seen.
    task automatic issue(input logic [31:0] w, input logic z, input int d);
        int cnt;
        int waited;
        cnt = 0;
        waited = 0;
        n_cyc = 0;
        timeout = 1'b0;
        @(negedge clk);
        bus.alu_zero_flag = z;
        bus.mem_ack = 1'b0;
        bus.instr = w;
        bus.instr_valid = 1'b1;
        while (!bus.instr_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.instr_ready) begin
            timeout = 1'b1;
            bus.instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr = $urandom;
        for (int i = 1; i < 40; i++) begin
            #1;
            bus.mem_ack = bus.mem_req && (cnt == d);
            #1;
            sample(tr[i]);
            if (bus.mem_req) cnt++;
            if (tr[i].ready) begin
                n_cyc = i;
                break;
            end
            @(negedge clk);
            bus.mem_ack = 1'b0;
        end
        bus.mem_ack = 1'b0;
        if (n_cyc == 0) timeout = 1'b1;
    endtask

    task automatic test_reset();
        int k;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.alu_zero_flag = 1'b0;
        bus.mem_ack = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (outs_now() !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", outs_now());
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", bus.instr_ready);
        end
        // LW x1,0(x2) left waiting in MEM, then reset asynchronously
        bus.instr = 32'h00012083;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        k = 0;
        while (!bus.mem_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_reach_mem got mem_req=%b want 1", bus.mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (outs_now() !== 17'd0) begin
            errors++;
            $display("FAIL reset_async_clear got %h want 0", outs_now());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.instr_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b mem_req=%b want 1 0", bus.instr_ready, bus.mem_req);
        end
    endtask

    task automatic test_add_sub();
        logic [31:0] words[2];
        logic        sub[2];
        words = '{32'h00208033, 32'h40208033};
        sub = '{1'b0, 1'b1};
        for (int t = 0; t < 2; t++) begin
            issue(words[t], 1'($urandom_range(0, 1)), 0);
            checks++;
            if (timeout || n_cyc != 4) begin
                errors++;
                $display("FAIL addsub_len[%0d] got %0d want 4", t, n_cyc);
            end
            checks++;
            if ({tr[2].op, tr[2].neg, tr[2].add1} !== {3'b000, sub[t], sub[t]}) begin
                errors++;
                $display("FAIL addsub_exec[%0d] got %b want %b", t,
                         {tr[2].op, tr[2].neg, tr[2].add1}, {3'b000, sub[t], sub[t]});
            end
            checks++;
            if ({tr[1].rwe, tr[2].rwe, tr[3].rwe, tr[4].rwe, tr[3].pwe} !== 5'b00101) begin
                errors++;
                $display("FAIL addsub_wb[%0d] got %b want 00101", t,
                         {tr[1].rwe, tr[2].rwe, tr[3].rwe, tr[4].rwe, tr[3].pwe});
            end
        end
    endtask

    task automatic test_shift();
        issue(32'h4020D093, 1'b0, 0);
        checks++;
        if ({tr[2].op, tr[2].sign, tr[2].b_sel} !== {3'b101, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL srai_exec got %b want 10111", {tr[2].op, tr[2].sign, tr[2].b_sel});
        end
        issue(32'h0020D093, 1'b0, 0);
        checks++;
        if ({tr[2].op, tr[2].sign, tr[2].b_sel} !== {3'b101, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL srli_exec got %b want 10101", {tr[2].op, tr[2].sign, tr[2].b_sel});
        end
    endtask

    task automatic test_branch();
        logic [31:0] words[3];
        logic        zf[3];
        logic        psel[3];
        logic [2:0]  op[3];
        words = '{32'h00208063, 32'h0020C063, 32'h0020F063};
        zf    = '{1'b1, 1'b1, 1'b0};
        psel  = '{1'b1, 1'b0, 1'b0};
        op    = '{3'b000, 3'b010, 3'b011};
        for (int t = 0; t < 3; t++) begin
            issue(words[t], zf[t], 0);
            checks++;
            if (timeout || n_cyc != 3) begin
                errors++;
                $display("FAIL branch_len[%0d] got %0d want 3", t, n_cyc);
            end
            checks++;
            if ({tr[2].pwe, tr[2].psel, tr[2].op} !== {1'b1, psel[t], op[t]}) begin
                errors++;
                $display("FAIL branch_exec[%0d] got %b want %b", t,
                         {tr[2].pwe, tr[2].psel, tr[2].op}, {1'b1, psel[t], op[t]});
            end
        end
    endtask

    task automatic test_load_store();
        int mreq_cnt;
        int rwe_cnt;
        issue(32'h00012083, 1'b0, 3);
        mreq_cnt = 0;
        for (int i = 1; i < 40; i++) if (i < n_cyc && tr[i].mreq) mreq_cnt++;
        checks++;
        if (timeout || n_cyc != 8 || mreq_cnt != 4) begin
            errors++;
            $display("FAIL lw_timing got len=%0d mem_req=%0d want 8 4", n_cyc, mreq_cnt);
        end
        checks++;
        if ({tr[7].rwe, tr[7].pwe, tr[7].wb, tr[7].mreq} !== 5'b11010) begin
            errors++;
            $display("FAIL lw_wb got %b want 11010", {tr[7].rwe, tr[7].pwe, tr[7].wb, tr[7].mreq});
        end
        issue(32'h00112023, 1'b0, 0);
        rwe_cnt = 0;
        for (int i = 1; i < 40; i++) if (i <= n_cyc && tr[i].rwe) rwe_cnt++;
        checks++;
        if (timeout || n_cyc != 4 || rwe_cnt != 0) begin
            errors++;
            $display("FAIL sw_timing got len=%0d reg_we=%0d want 4 0", n_cyc, rwe_cnt);
        end
        checks++;
        if ({tr[3].mreq, tr[3].mwe, tr[3].pwe, tr[3].psel} !== 4'b1110) begin
            errors++;
            $display("FAIL sw_ack got %b want 1110", {tr[3].mreq, tr[3].mwe, tr[3].pwe, tr[3].psel});
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] w;
            mdl_t m;
            logic z, exp_psel, psel_at;
            logic [1:0] wb_at;
            int d, exp_n, exp_rwe, exp_mreq;
            int pwe_cnt, rwe_cnt, mreq_cnt, ovl, alu_bad, mwe_bad, ill_cnt;
            w = rand_instr();
            m = model(w);
            z = 1'($urandom_range(0, 1));
            d = $urandom_range(0, 3);
            exp_n    = (m.kind == K_BR) ? 3 : (m.kind == K_LD) ? 5 + d : (m.kind == K_ST) ? 4 + d : 4;
            exp_rwe  = (m.kind == K_BR || m.kind == K_ST) ? 0 : 1;
            exp_mreq = (m.kind == K_LD || m.kind == K_ST) ? d + 1 : 0;
            exp_psel = (m.kind == K_BR) ? mdl_taken(w[14:12], z) : m.jump;
            issue(w, z, d);
            checks++;
            if (timeout || n_cyc != exp_n) begin
                errors++;
                $display("FAIL rand_len instr=%h got %0d want %0d", w, n_cyc, exp_n);
                continue;
            end
            pwe_cnt = 0; rwe_cnt = 0; mreq_cnt = 0; ovl = 0;
            alu_bad = 0; mwe_bad = 0; ill_cnt = 0;
            psel_at = 1'b0; wb_at = 2'b00;
            for (int i = 1; i < n_cyc; i++) begin
                if (tr[i].pwe) begin pwe_cnt++; psel_at = tr[i].psel; end
                if (tr[i].rwe) begin rwe_cnt++; wb_at = tr[i].wb; end
                if (tr[i].mreq) begin
                    mreq_cnt++;
                    if (tr[i].mwe !== (m.kind == K_ST)) mwe_bad++;
                end
                if (tr[i].rwe && tr[i].mreq) ovl++;
                if (tr[i].ill) ill_cnt++;
                if (i == 1 && {tr[i].op, tr[i].neg, tr[i].add1, tr[i].sign} !== 6'd0) alu_bad++;
                if (i >= 2 && ({tr[i].op, tr[i].neg, tr[i].add1, tr[i].sign} !== {m.op, m.neg, m.add1, m.sign}
                    || (!m.ops_dc && {tr[i].a_sel, tr[i].b_sel} !== {m.a_sel, m.b_sel})))
                    alu_bad++;
            end
            checks++;
            if (pwe_cnt != 1 || psel_at !== exp_psel) begin
                errors++;
                $display("FAIL rand_pc instr=%h z=%b got pc_we=%0d pc_sel=%b want 1 %b", w, z, pwe_cnt, psel_at, exp_psel);
            end
            checks++;
            if (rwe_cnt != exp_rwe || (exp_rwe == 1 && wb_at !== m.wb)) begin
                errors++;
                $display("FAIL rand_wb instr=%h got reg_we=%0d wb_sel=%b want %0d %b", w, rwe_cnt, wb_at, exp_rwe, m.wb);
            end
            checks++;
            if (mreq_cnt != exp_mreq || mwe_bad != 0 || ovl != 0) begin
                errors++;
                $display("FAIL rand_mem instr=%h got mem_req=%0d we_bad=%0d overlap=%0d want %0d 0 0", w, mreq_cnt, mwe_bad, ovl, exp_mreq);
            end
            checks++;
            if (alu_bad != 0 || ill_cnt != 0) begin
                errors++;
                $display("FAIL rand_alu instr=%h got bad_cycles=%0d illegal=%0d want 0 0", w, alu_bad, ill_cnt);
            end
            checks++;
            if ({tr[n_cyc].op, tr[n_cyc].neg, tr[n_cyc].add1, tr[n_cyc].sign,
                 tr[n_cyc].mreq, tr[n_cyc].rwe, tr[n_cyc].pwe} !== 9'd0) begin
                errors++;
                $display("FAIL rand_fetch_idle instr=%h got op=%b strobes=%b want 0", w, tr[n_cyc].op,
                         {tr[n_cyc].mreq, tr[n_cyc].rwe, tr[n_cyc].pwe});
            end
        end
    endtask

    task automatic test_trap();
        int bad;
        int waited;
        bad = 0;
        waited = 0;
        @(negedge clk);
        bus.instr = 32'h0000007F;
        bus.instr_valid = 1'b1;
        while (!bus.instr_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (bus.instr_ready !== 1'b0 || bus.reg_we !== 1'b0 || bus.pc_we !== 1'b0 || bus.mem_req !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL trap_quiet got %0d active cycles want 0", bad);
        end
        checks++;
        if (bus.illegal !== 1'b1) begin
            errors++;
            $display("FAIL trap_illegal got %b want 1", bus.illegal);
        end
        bus.instr_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.illegal !== 1'b0 || bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL trap_exit got illegal=%b ready=%b want 0 1", bus.illegal, bus.instr_ready);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_shift();
        test_branch();
        test_load_store();
        test_random();
        test_trap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
